// File: rtl/mmio_pkg.sv
// ---------------------------------------------------------------------------
// mmio_pkg
// Shared definitions for the memory-mapped I/O responder:
//   - byte offsets of every register inside the I/O window
//   - indices of the performance counters inside the counter bundle
//   - the TX holding-register state type
//   - a helper that extracts the register offset from a full byte address
// ---------------------------------------------------------------------------
package mmio_pkg;

  // Register offsets from IO_BASE (byte addresses, word aligned)
  localparam logic [7:0] MMIO_UART_CTRL  = 8'h00;
  localparam logic [7:0] MMIO_UART_RX    = 8'h04;
  localparam logic [7:0] MMIO_UART_TX    = 8'h08;
  localparam logic [7:0] MMIO_CYCLE      = 8'h10;
  localparam logic [7:0] MMIO_INST       = 8'h14;
  localparam logic [7:0] MMIO_CNT_RST    = 8'h18;
  localparam logic [7:0] MMIO_BR_TOTAL   = 8'h1C;
  localparam logic [7:0] MMIO_BR_CORRECT = 8'h20;

  // Positions of the counters inside the packed counter bundle
  localparam int CNT_CYCLE      = 0;
  localparam int CNT_INST       = 1;
  localparam int CNT_BR_TOTAL   = 2;
  localparam int CNT_BR_CORRECT = 3;
  localparam int NUM_CNT        = 4;

  // Single-entry TX holding register
  typedef enum logic {
    TX_EMPTY = 1'b0,
    TX_FULL  = 1'b1
  } tx_state_e;

  // Registers are word wide; byte-lane bits of the address are ignored so
  // an unaligned access hits the word that contains it.
  function automatic logic [7:0] mmio_word_offset(input logic [31:0] addr);
    return {addr[7:2], 2'b00};
  endfunction

endpackage

// File: rtl/mmio_io_responder_if.sv
// ---------------------------------------------------------------------------
// mmio_io_responder_if
// Execute-stage load/store request bus toward the I/O responder.
//   req_addr  : byte address of the access
//   req_wdata : store data (already forwarded)
//   req_we    : qualified store strobe
//   req_re    : qualified load strobe
//   rdata     : registered load result, valid the cycle after req_re
// Modports: master = CPU side, slave = responder side.
// ---------------------------------------------------------------------------
interface mmio_io_responder_if;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_we;
  logic        req_re;
  logic [31:0] rdata;

  modport master (
    output req_addr,
    output req_wdata,
    output req_we,
    output req_re,
    input  rdata
  );

  modport slave (
    input  req_addr,
    input  req_wdata,
    input  req_we,
    input  req_re,
    output rdata
  );
endinterface

// File: rtl/mmio_perf_counters.sv
// ---------------------------------------------------------------------------
// mmio_perf_counters
// Four free-running performance counters (cycle, retired instruction,
// total branch, correctly predicted branch), each CNT_W bits wide and
// wrapping modulo 2^CNT_W. A clear request wins over a same-cycle increment.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   clr          : clear all counters at the next edge
//   inst_retire  : one instruction retired this cycle
//   is_br        : the retiring instruction is a conditional branch
//   br_correct   : the branch prediction was correct
//   cnt          : packed bundle of counters, indexed by CNT_* from mmio_pkg
// ---------------------------------------------------------------------------
module mmio_perf_counters
  import mmio_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clr,
  input  logic                           inst_retire,
  input  logic                           is_br,
  input  logic                           br_correct,
  output logic [NUM_CNT-1:0][CNT_W-1:0]  cnt
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Increment enable per counter; branch qualifiers only count when an
  // instruction actually retires.
  logic [NUM_CNT-1:0] inc;

  assign inc[CNT_CYCLE]      = 1'b1;
  assign inc[CNT_INST]       = inst_retire;
  assign inc[CNT_BR_TOTAL]   = inst_retire & is_br;
  assign inc[CNT_BR_CORRECT] = inst_retire & is_br & br_correct;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_reg;
      logic [CNT_W-1:0] cnt_next;

      always_comb begin
        cnt_next = cnt_reg;
        if (clr) begin
          cnt_next = '0;
        end else if (inc[gi]) begin
          cnt_next = cnt_reg + ONE;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_next;
        end
      end

      assign cnt[gi] = cnt_reg;
    end
  endgenerate

endmodule

// File: rtl/mmio_io_responder.sv
// ---------------------------------------------------------------------------
// mmio_io_responder
// Memory-mapped I/O responder for the 0x8000_00xx window. Decodes loads and
// stores from the execute stage, owns the UART TX holding register, issues
// the UART RX pop strobe, hosts the performance counters and registers the
// load result.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   bus            : request bus (slave side), see mmio_io_responder_if
//   inst_retire    : one non-bubble instruction left execute this cycle
//   is_br          : retiring instruction is a conditional branch
//   br_correct     : branch prediction matched the outcome
//   uart_tx_data   : byte presented to the UART transmitter
//   uart_tx_valid  : uart_tx_data holds a pending byte
//   uart_tx_ready  : transmitter accepts the byte this cycle
//   uart_rx_data   : byte from the UART receiver
//   uart_rx_valid  : receiver holds an unread byte
//   uart_rx_ready  : combinational pop strobe to the receiver
// Parameters:
//   IO_BASE : window base, only bits [31:28] are decoded
//   CNT_W   : counter width (reads are zero-extended to 32 bits, CNT_W <= 32)
// ---------------------------------------------------------------------------
module mmio_io_responder
  import mmio_pkg::*;
#(
  parameter logic [31:0] IO_BASE = 32'h8000_0000,
  parameter int          CNT_W   = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mmio_io_responder_if.slave    bus,
  input  logic                  inst_retire,
  input  logic                  is_br,
  input  logic                  br_correct,
  output logic [7:0]            uart_tx_data,
  output logic                  uart_tx_valid,
  input  logic                  uart_tx_ready,
  input  logic [7:0]            uart_rx_data,
  input  logic                  uart_rx_valid,
  output logic                  uart_rx_ready
);

  // -------------------------------------------------------------------------
  // Address decode
  // -------------------------------------------------------------------------
  logic       in_win;
  logic [7:0] offset;
  logic       rd_sel;
  logic       wr_sel;

  assign in_win = (bus.req_addr[31:28] == IO_BASE[31:28]);
  assign offset = mmio_word_offset(bus.req_addr);
  assign rd_sel = bus.req_re & in_win;
  assign wr_sel = bus.req_we & in_win;

  // Address and data bits that carry no meaning for this block
  logic unused_bits;
  assign unused_bits = ^{bus.req_addr[27:8], bus.req_addr[1:0], bus.req_wdata[31:8]};

  // -------------------------------------------------------------------------
  // Performance counters
  // -------------------------------------------------------------------------
  logic                          cnt_clr;
  logic [NUM_CNT-1:0][CNT_W-1:0] cnt;
  logic [31:0]                   cnt_rd [NUM_CNT];

  assign cnt_clr = wr_sel & (offset == MMIO_CNT_RST);

  mmio_perf_counters #(
    .CNT_W (CNT_W)
  ) u_perf_counters (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (cnt_clr),
    .inst_retire (inst_retire),
    .is_br       (is_br),
    .br_correct  (br_correct),
    .cnt         (cnt)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CNT; gi++) begin : g_cnt_rd
      assign cnt_rd[gi] = 32'(cnt[gi]);
    end
  endgenerate

  // -------------------------------------------------------------------------
  // TX holding register
  // -------------------------------------------------------------------------
  tx_state_e  tx_state_reg;
  tx_state_e  tx_state_next;
  logic [7:0] tx_data_reg;
  logic [7:0] tx_data_next;
  logic       tx_load;
  logic       tx_fire;

  assign tx_load = wr_sel & (offset == MMIO_UART_TX);
  assign tx_fire = (tx_state_reg == TX_FULL) & uart_tx_ready;

  always_comb begin
    tx_state_next = tx_state_reg;
    tx_data_next  = tx_data_reg;
    case (tx_state_reg)
      TX_EMPTY: begin
        if (tx_load) begin
          tx_state_next = TX_FULL;
          tx_data_next  = bus.req_wdata[7:0];
        end
      end
      TX_FULL: begin
        // A store while full only lands if the slot frees up this cycle;
        // otherwise the byte is dropped and software must poll TX ready.
        if (tx_fire) begin
          if (tx_load) begin
            tx_data_next = bus.req_wdata[7:0];
          end else begin
            tx_state_next = TX_EMPTY;
          end
        end
      end
      default: begin
        tx_state_next = TX_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_reg <= TX_EMPTY;
      tx_data_reg  <= 8'h00;
    end else begin
      tx_state_reg <= tx_state_next;
      tx_data_reg  <= tx_data_next;
    end
  end

  assign uart_tx_valid = (tx_state_reg == TX_FULL);
  assign uart_tx_data  = tx_data_reg;

  // -------------------------------------------------------------------------
  // RX pop: one-cycle strobe in the request cycle, only when a byte waits.
  // Gated by rst_n so a held load cannot pop the receiver during reset.
  // -------------------------------------------------------------------------
  assign uart_rx_ready = rst_n & rd_sel & (offset == MMIO_UART_RX) & uart_rx_valid;

  // -------------------------------------------------------------------------
  // Load data: selected in the request cycle, registered for the next cycle,
  // held while no load is issued.
  // -------------------------------------------------------------------------
  logic [31:0] rdata_reg;
  logic [31:0] rdata_next;

  always_comb begin
    rdata_next = rdata_reg;
    if (bus.req_re) begin
      rdata_next = 32'h0;
      if (in_win) begin
        case (offset)
          MMIO_UART_CTRL:  rdata_next = {30'b0, uart_rx_valid, ~uart_tx_valid};
          MMIO_UART_RX:    rdata_next = {24'b0, uart_rx_data};
          MMIO_CYCLE:      rdata_next = cnt_rd[CNT_CYCLE];
          MMIO_INST:       rdata_next = cnt_rd[CNT_INST];
          MMIO_BR_TOTAL:   rdata_next = cnt_rd[CNT_BR_TOTAL];
          MMIO_BR_CORRECT: rdata_next = cnt_rd[CNT_BR_CORRECT];
          default:         rdata_next = 32'h0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_reg <= 32'h0;
    end else begin
      rdata_reg <= rdata_next;
    end
  end

  assign bus.rdata = rdata_reg;

endmodule

// File: tb/tb_mmio_io_responder.sv
// ---------------------------------------------------------------------------
// tb_mmio_io_responder
// Directed stimulus with a scoreboard: each load pushes its expected rdata,
// each accepted TX store pushes its expected byte; monitor processes pop and
// compare when the DUT presents load data or completes a TX handshake.
// A second instance with 4-bit counters exercises counter wrap-around.
// ---------------------------------------------------------------------------
module tb_mmio_io_responder;
  import mmio_pkg::*;

  localparam logic [31:0] BASE = 32'h8000_0000;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  logic clk;
  logic rst_n;

  logic       inst_retire, is_br, br_correct;
  logic [7:0] uart_tx_data;
  logic       uart_tx_valid, uart_tx_ready;
  logic [7:0] uart_rx_data;
  logic       uart_rx_valid, uart_rx_ready;

  // Narrow instance side signals
  logic [7:0] w_tx_data;
  logic       w_tx_valid, w_rx_ready;

  mmio_io_responder_if bus ();
  mmio_io_responder_if bus_w ();

  mmio_io_responder #(.IO_BASE(BASE), .CNT_W(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .inst_retire   (inst_retire),
    .is_br         (is_br),
    .br_correct    (br_correct),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_valid (uart_tx_valid),
    .uart_tx_ready (uart_tx_ready),
    .uart_rx_data  (uart_rx_data),
    .uart_rx_valid (uart_rx_valid),
    .uart_rx_ready (uart_rx_ready)
  );

  mmio_io_responder #(.IO_BASE(BASE), .CNT_W(4)) dut_w (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus_w),
    .inst_retire   (1'b0),
    .is_br         (1'b0),
    .br_correct    (1'b0),
    .uart_tx_data  (w_tx_data),
    .uart_tx_valid (w_tx_valid),
    .uart_tx_ready (1'b0),
    .uart_rx_data  (8'h00),
    .uart_rx_valid (1'b0),
    .uart_rx_ready (w_rx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int hi_cnt = 0;
  int rx_cnt = 0;

  exp_t       exp_q[$];
  exp_t       exp_w_q[$];
  logic [7:0] tx_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  // Counting monitors for pulse/duration checks
  always @(negedge clk) begin
    if (uart_tx_valid) hi_cnt++;
    if (uart_rx_ready) rx_cnt++;
  end

  // Scoreboard monitor: load data appears the cycle after req_re; TX bytes
  // leave on valid & ready.
  initial begin
    logic pend, pend_w;
    exp_t e;
    logic [7:0] b;
    forever begin
      @(posedge clk);
      pend   = bus.req_re;
      pend_w = bus_w.req_re;
      @(negedge clk);
      if (pend) begin
        if (exp_q.size() == 0) begin
          chk("rdata_unexpected", bus.rdata, 32'hxxxx_xxxx);
        end else begin
          e = exp_q.pop_front();
          chk(e.name, bus.rdata, e.val);
        end
      end
      if (pend_w) begin
        if (exp_w_q.size() == 0) begin
          chk("rdata_w_unexpected", bus_w.rdata, 32'hxxxx_xxxx);
        end else begin
          e = exp_w_q.pop_front();
          chk(e.name, bus_w.rdata, e.val);
        end
      end
      if (uart_tx_valid && uart_tx_ready) begin
        if (tx_q.size() == 0) begin
          chk("tx_unexpected", {24'h0, uart_tx_data}, 32'hxxxx_xxxx);
        end else begin
          b = tx_q.pop_front();
          chk("tx_byte", {24'h0, uart_tx_data}, {24'h0, b});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [7:0] off, input logic [31:0] val, input string name);
    exp_q.push_back('{name: name, val: val});
    bus.req_addr = BASE | {24'h0, off};
    bus.req_re   = 1'b1;
    tick();
    bus.req_re   = 1'b0;
  endtask

  task automatic rd_w(input logic [7:0] off, input logic [31:0] val, input string name);
    exp_w_q.push_back('{name: name, val: val});
    bus_w.req_addr = BASE | {24'h0, off};
    bus_w.req_re   = 1'b1;
    tick();
    bus_w.req_re   = 1'b0;
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] data);
    bus.req_addr  = BASE | {24'h0, off};
    bus.req_wdata = data;
    bus.req_we    = 1'b1;
    tick();
    bus.req_we    = 1'b0;
  endtask

  // {inst_retire, is_br, br_correct}: 8 retires, 3 branches, 2 correct
  logic [2:0] ret_vec [9] = '{3'b111, 3'b101, 3'b011, 3'b110, 3'b100,
                              3'b111, 3'b100, 3'b100, 3'b100};

  initial begin
    int hi_start, rx_start;

    rst_n = 1'b0;
    bus.req_addr = '0;   bus.req_wdata = '0;   bus.req_we = 1'b0;   bus.req_re = 1'b0;
    bus_w.req_addr = '0; bus_w.req_wdata = '0; bus_w.req_we = 1'b0; bus_w.req_re = 1'b0;
    inst_retire = 1'b0; is_br = 1'b0; br_correct = 1'b0;
    uart_tx_ready = 1'b0; uart_rx_data = 8'h00; uart_rx_valid = 1'b0;

    // Reset state
    #2;
    chk("rst_rdata", bus.rdata, 32'h0);
    chk("rst_tx_valid", {31'h0, uart_tx_valid}, 32'h0);
    chk("rst_tx_data", {24'h0, uart_tx_data}, 32'h0);
    chk("rst_rx_ready", {31'h0, uart_rx_ready}, 32'h0);
    #10 rst_n = 1'b1;

    // Cycle counter after 10 idle edges
    repeat (10) tick();
    rd(MMIO_CYCLE, 32'd10, "cycle_after_10");
    chk("idle_tx_valid", {31'h0, uart_tx_valid}, 32'h0);

    // Wrap of a 4-bit counter: cycle 15 -> 15, 16 -> 0, 17 -> 1
    repeat (4) tick();
    rd_w(MMIO_CYCLE, 32'd15, "narrow_cycle_15");
    rd_w(MMIO_CYCLE, 32'd0,  "narrow_cycle_wrap");
    rd_w(MMIO_CYCLE, 32'd1,  "narrow_cycle_after_wrap");
    rd(MMIO_CYCLE, 32'd18, "cycle_18_no_wrap");

    // TX: hold 6 cycles, second store dropped
    hi_start = hi_cnt;
    tx_q.push_back(8'h41);
    wr(MMIO_UART_TX, 32'h0000_0041);
    rd(MMIO_UART_CTRL, 32'h0, "ctrl_tx_busy");
    wr(MMIO_UART_TX, 32'h0000_0042);
    repeat (3) tick();
    uart_tx_ready = 1'b1;
    tick();
    uart_tx_ready = 1'b0;
    repeat (3) tick();
    chk("tx_valid_cycles", 32'(hi_cnt - hi_start), 32'd6);
    rd(MMIO_UART_CTRL, 32'h1, "ctrl_tx_idle");

    // TX: store accepted in the cycle the handshake completes
    tx_q.push_back(8'h43);
    wr(MMIO_UART_TX, 32'h0000_0043);
    uart_tx_ready = 1'b1;
    tx_q.push_back(8'h44);
    wr(MMIO_UART_TX, 32'h0000_0044);
    tick();
    uart_tx_ready = 1'b0;
    tick();
    chk("tx_drained", {31'h0, uart_tx_valid}, 32'h0);

    // RX pop with and without a waiting byte
    uart_rx_valid = 1'b1;
    uart_rx_data  = 8'h5A;
    rx_start = rx_cnt;
    rd(MMIO_UART_CTRL, 32'h3, "ctrl_rx_valid");
    rd(MMIO_UART_RX, 32'h0000_005A, "rx_data");
    tick();
    chk("rx_pop_pulses", 32'(rx_cnt - rx_start), 32'd1);
    uart_rx_valid = 1'b0;
    uart_rx_data  = 8'h33;
    rx_start = rx_cnt;
    rd(MMIO_UART_RX, 32'h0000_0033, "rx_stale");
    tick();
    chk("rx_no_pop", 32'(rx_cnt - rx_start), 32'd0);

    // Unmapped / write-only offsets read 0; store to unmapped is ignored
    rd(8'h0C, 32'h0, "unmapped_0c");
    rd(MMIO_UART_TX, 32'h0, "tx_reg_reads_0");
    wr(8'h0C, 32'h0000_00FF);
    chk("unmapped_store_ignored", {31'h0, uart_tx_valid}, 32'h0);

    // Counters: retire pattern, then pre-increment read, then clear
    for (int i = 0; i < 9; i++) begin
      {inst_retire, is_br, br_correct} = ret_vec[i];
      tick();
    end
    {inst_retire, is_br, br_correct} = 3'b000;
    rd(MMIO_INST, 32'd8, "inst_count");
    rd(MMIO_BR_TOTAL, 32'd3, "br_total");
    rd(MMIO_BR_CORRECT, 32'd2, "br_correct");
    inst_retire = 1'b1;
    rd(MMIO_INST, 32'd8, "inst_pre_increment");
    inst_retire = 1'b0;
    rd(MMIO_INST, 32'd9, "inst_post_increment");
    {inst_retire, is_br, br_correct} = 3'b111;
    wr(MMIO_CNT_RST, 32'hDEAD_BEEF);
    {inst_retire, is_br, br_correct} = 3'b000;
    rd(MMIO_CYCLE, 32'd0, "clr_cycle");
    rd(MMIO_INST, 32'd0, "clr_inst");
    rd(MMIO_BR_TOTAL, 32'd0, "clr_br_total");
    rd(MMIO_BR_CORRECT, 32'd0, "clr_br_correct");
    rd(MMIO_CYCLE, 32'd4, "cycle_recount");

    // rdata holds while idle
    repeat (3) tick();
    chk("rdata_hold", bus.rdata, 32'd4);

    // Simultaneous load and store to the TX register: load returns 0,
    // store loads the byte.
    exp_q.push_back('{name: "rdwr_same_cycle", val: 32'h0});
    bus.req_addr  = BASE | {24'h0, MMIO_UART_TX};
    bus.req_wdata = 32'h0000_0077;
    bus.req_re    = 1'b1;
    bus.req_we    = 1'b1;
    tick();
    bus.req_re    = 1'b0;
    bus.req_we    = 1'b0;
    chk("rdwr_tx_full", {31'h0, uart_tx_valid}, 32'h1);

    // Asynchronous reset while TX is full
    rst_n = 1'b0;
    #1;
    chk("async_rst_tx_valid", {31'h0, uart_tx_valid}, 32'h0);
    bus.req_addr  = BASE | {24'h0, MMIO_UART_RX};
    bus.req_re    = 1'b1;
    uart_rx_valid = 1'b1;
    #1;
    chk("rst_no_rx_pop", {31'h0, uart_rx_ready}, 32'h0);
    chk("async_rst_rdata", bus.rdata, 32'h0);
    bus.req_re    = 1'b0;
    uart_rx_valid = 1'b0;
    #1 rst_n = 1'b1;
    tick();
    rd(MMIO_CYCLE, 32'd1, "cycle_after_rst");
    repeat (3) tick();

    chk("rd_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("rd_w_queue_empty", 32'(exp_w_q.size()), 32'd0);
    chk("tx_queue_empty", 32'(tx_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mmio_io_responder.md
# mmio_io_responder

Memory-mapped I/O responder on the CPU's `0x8000_00xx` window. It sits beside DMEM on the execute/memory boundary and services the loads and stores that the execute-stage control decodes to I/O addresses. It owns:
- the UART transmit holding register and the UART receive pop handshake;
- the cycle, instruction and branch performance counters;
- the counter-reset strobe.

## Interface
Parameters:
- `IO_BASE`, `32'h8000_0000`: base of the I/O window; only `addr[31:28] == IO_BASE[31:28]` is decoded.
- `CNT_W`, `32`: width of every performance counter. Read data is zero-extended to 32 bits.

Ports:
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst_n` input 1: reset, asynchronous assert and active-low.
- `req_addr` input 32: byte address of the execute-stage access.
- `req_wdata` input 32: store data, already forwarded.
- `req_we` input 1: store to this block; already qualified by the execute-stage decode and by "not stalled/flushed".
- `req_re` input 1: load from this block; qualified the same way.
- `rdata` output 32: load result, registered, valid the cycle after `req_re`.
- `inst_retire` input 1: one non-bubble instruction left execute this cycle.
- `is_br` input 1: the retiring instruction is a conditional branch.
- `br_correct` input 1: branch prediction matched the outcome; meaningful only with `is_br`.
- `uart_tx_data` output 8: byte presented to the UART transmitter.
- `uart_tx_valid` output 1: `uart_tx_data` holds a pending byte.
- `uart_tx_ready` input 1: the transmitter accepts the byte this cycle.
- `uart_rx_data` input 8: byte from the UART receiver.
- `uart_rx_valid` input 1: the receiver holds an unread byte.
- `uart_rx_ready` output 1: pop strobe to the receiver.

## Operation
Address map (word offsets from `IO_BASE`):
- `0x00` R, UART control: `{30'b0, uart_rx_valid, ~uart_tx_valid}`. Bit 0 = TX ready, bit 1 = RX valid.
- `0x04` R, RX data: `{24'b0, uart_rx_data}`. Pops the receiver.
- `0x08` W, TX data: `req_wdata[7:0]` loads the TX holding register.
- `0x10` R: cycle counter.
- `0x14` R: retired-instruction counter.
- `0x18` W: any store clears all counters.
- `0x1C` R: total branch counter.
- `0x20` R: correctly predicted branch counter.
- Loads to any other offset return 0. Stores to any other offset are ignored.

TX holding register (single-entry buffer, two states):
- EMPTY→FULL on a store to `0x08`; latches the byte and raises `uart_tx_valid`.
- FULL→EMPTY on `uart_tx_valid & uart_tx_ready`.
- Store to `0x08` while FULL and the handshake is not completing: the byte is dropped. Software polls control bit 0.
- Store to `0x08` while FULL in the same cycle the handshake completes: the new byte is accepted and the state stays FULL.

RX pop:
- `uart_rx_ready = req_re & (offset == 0x04) & uart_rx_valid`. This is combinational, one cycle, in the request cycle.
- A read of `0x04` with `uart_rx_valid` low returns the stale `uart_rx_data` and does not pop.

Counters:
- The cycle counter increments every cycle.
- The instruction counter increments on `inst_retire`.
- The total branch counter increments on `inst_retire & is_br`.
- The correct-branch counter increments on `inst_retire & is_br & br_correct`.
- All counters wrap modulo 2^`CNT_W`.
- A store to `0x18` clears all counters at the next edge. Clear has priority over a same-cycle increment: the value after that edge is 0.

## Timing
- Reset values: `rdata`=0, `uart_tx_valid`=0, `uart_tx_data`=0, all counters 0, TX state EMPTY. `uart_rx_ready` is combinational and therefore 0 while `req_re`=0.
- Load latency is 1 cycle. `rdata` captures the value selected in the request cycle, so a counter read returns the pre-increment value of that cycle.
- `rdata` holds its value when no `req_re` is asserted.
- Control bit 0 reflects the registered `uart_tx_valid`. It reads 0 in the cycle right after an accepted TX store.
- `req_re` and `req_we` in the same cycle: both take effect independently.
- Asserting `rst_n` low mid-transfer drops any pending TX byte immediately. No `uart_rx_ready` is issued during reset.

## Structure
- Shared package `mmio_pkg` holds:
  - offset constants `MMIO_UART_CTRL`, `MMIO_UART_RX`, `MMIO_UART_TX`, `MMIO_CYCLE`, `MMIO_INST`, `MMIO_CNT_RST`, `MMIO_BR_TOTAL`, `MMIO_BR_CORRECT`;
  - the TX state enum.
- Sub-module `mmio_perf_counters` holds the four counters with the clear/increment priority. The top level keeps the decode, the TX buffer, the RX pop and the `rdata` register.

## Test plan
- Reset, 10 idle cycles, then load `0x80000010` → `rdata`=10 one cycle later (±0 exact); `uart_tx_valid`=0.
- Store `0x41` to `0x80000008` with `uart_tx_ready`=0 for 5 cycles, then 1 → `uart_tx_valid` high for 6 cycles with `uart_tx_data`=`0x41`. A second store `0x42` during the hold is dropped.
- `uart_rx_valid`=1, `uart_rx_data`=`0x5A`, load `0x80000004` → `uart_rx_ready` pulses for exactly 1 cycle; `rdata`=`0x0000005A` next cycle. Repeat with valid=0 → no pulse.
- 8 retires, 3 branches, 2 correct; then loads `0x14`/`0x1C`/`0x20` → 8/3/2. Then store `0x18` in a cycle with `inst_retire`=1 → all counters read 0 at the next edge (cycle counter counts up again from there).
- Load cycle counter preset to `0xFFFFFFFF` → wraps to 0. Assert `rst_n` low while TX is FULL → `uart_tx_valid` drops without waiting for a clock edge.
